div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit signed/unsigned integer divider for the execute stage of the five-stage MIPS pipeline. It produces the `stall_div` request that the hazard unit turns into stallF/stallD/stallE, which freezes the divide instruction in E until the quotient and remainder are ready. It honours the pipeline-wide exception flush, and its packed result is written to HI/LO by the following stages.

## Interface
- No parameters. Operand width is fixed at 32; iteration count is fixed at 32.
- `clk`  in  1  sole clock, rising-edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  a DIV/DIVU is in E. Held stable by the pipeline for as long as `stall_div_o` is high.
- `signed_i`  in  1  1 = DIV, 0 = DIVU. Sampled at accept.
- `opdata1_i`  in  32  dividend (post-forwarding rs). Sampled at accept.
- `opdata2_i`  in  32  divisor (post-forwarding rt). Sampled at accept.
- `annul_i`  in  1  exception flush (flushALL). Aborts any operation.
- `stall_div_o`  out  1  combinational: `start_i & ~annul_i & (state != DONE)`.
- `ready_o`  out  1  registered; high only in DONE.
- `result_o`  out  64  registered; {remainder[63:32] → HI, quotient[31:0] → LO}.

## Operation
- States: IDLE, ZERO, BUSY, DONE. Reset value is IDLE, with `result_o` = 0, `ready_o` = 0, and counter = 0.
- IDLE
  - If `start_i & ~annul_i` and divisor == 0: go to ZERO.
  - Else if `start_i & ~annul_i`: latch the operands and go to BUSY.
  - For the latch, when `signed_i` is set, latch |opdata1| and |opdata2| as unsigned two's-complement magnitudes, so |−2^31| = 0x8000_0000. Also latch `neg_q = signed & (op1[31]^op2[31])` and `neg_r = signed & op1[31]`.
  - Counter = 0.
- ZERO: `result_o` ← 64'h0. Go to DONE.
- BUSY, one restoring step per cycle on a 65-bit working register {rem[32:0], quo[31:0]}:
  - Shift left 1.
  - Trial subtract the divisor from rem.
  - If the result is non-negative, keep it and set the quotient LSB to 1.
  - Counter increments. After the 32nd step (counter == 31 → wrap), go to DONE.
  - On the transition, write `result_o` = {neg_r ? −rem : rem, neg_q ? −quo : quo}, all 32-bit wrap.
- DONE: `ready_o` = 1 and `stall_div_o` = 0, so the pipeline advances at this edge. Next state is IDLE unconditionally.
- `annul_i` in any state:
  - Next state is IDLE, with no result update and `ready_o` low next cycle.
  - `stall_div_o` drops in the same cycle.
- Overflow: DIV −2^31 / −1 gives quotient 0x8000_0000 and remainder 0. This is natural wrap, not trapped.
- `result_o` holds its last value until the next result is written.

## Timing
- Accept cycle is C0 (IDLE, `start_i` high). BUSY runs C1..C32. DONE is C33.
- `stall_div_o` is high C0..C32 (33 cycles) and low at C33. The instruction therefore spends 34 cycles in E.
- Divide-by-zero path: C0 IDLE, C1 ZERO, C2 DONE. Stall is high for 2 cycles.
- `ready_o` and `result_o` are valid together at DONE. M captures them at the end of that cycle.
- Back-to-back divides:
  - The second divide enters E at the DONE edge. The FSM is in IDLE and stall re-asserts combinationally at its C0.
  - There is no dead cycle beyond IDLE, and no double-issue of the first divide.
- Async reset mid-operation: immediate return to IDLE with all registers cleared. Stall then follows `start_i` only.
- `start_i` low while BUSY (not legal without annul) is ignored: the operation completes.

## Structure
- Shared CPU package (`defines`) holds:
  - state encodings DIV_IDLE/DIV_ZERO/DIV_BUSY/DIV_DONE;
  - DIV_ITER = 32;
  - HI/LO slice positions of the 64-bit result, shared with the hilo_reg writer.
- One natural sub-module: `div_step`, purely combinational. It takes the 65-bit working register and the divisor and returns the next working register. Everything else (FSM, counter, sign fix-up) stays in `div_unit`.

## Test plan
- DIVU 7 / 2 → `stall_div_o` high for 33 cycles, then `ready_o` = 1 at C33 with `result_o` = {32'h1, 32'h3}.
- DIV −7 / 2 (0xFFFF_FFF9, 2) → `result_o` = {32'hFFFF_FFFF, 32'hFFFF_FFFD}. DIV 7 / −2 → {32'h1, 32'hFFFF_FFFD}.
- DIV 0x8000_0000 / 0xFFFF_FFFF → {32'h0, 32'h8000_0000}. DIVU 0xFFFF_FFFF / 1 → {32'h0, 32'hFFFF_FFFF}.
- Divisor 0 → `ready_o` at C2, `result_o` = 64'h0, stall high exactly 2 cycles.
- `annul_i` at C10 → `stall_div_o` low in C10, FSM in IDLE at C11, `ready_o` never asserted, `result_o` unchanged from its previous value.
- Two back-to-back DIVU (100/7, then 9/3) → results {2, 14} and then {0, 3}, each ready after 34 E-cycles. A `resetn` pulse at C5 of a third divide → IDLE and `result_o` = 0 immediately.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM state encodings,
// iteration count, HI/LO slice positions and a conditional negate helper.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_BUSY = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    localparam int DIV_ITER  = 32;
    localparam int DIV_CNT_W = 5;

    // Result packing: remainder goes to HI, quotient goes to LO.
    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;

    // Two's-complement negate when en is set; 32-bit wrap.
    function automatic logic [31:0] neg_if(input logic en, input logic [31:0] v);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step on the {rem[32:0], quo[31:0]} working register.
module div_unit_step (
    input  logic [64:0] work_i,
    input  logic [31:0] divisor_i,
    output logic [64:0] work_o
);

    logic [33:0] rem_sh;
    logic [33:0] diff;

    // Shift left, trial-subtract the divisor, keep the difference if non-negative.
    always_comb begin
        rem_sh = work_i[64:31];
        diff   = rem_sh - {2'b00, divisor_i};
        if (!diff[33]) begin
            work_o = {diff[32:0], work_i[30:0], 1'b1};
        end else begin
            work_o = {work_i[63:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider for the execute stage.
// Holds the pipeline via stall_div_o until the packed {rem, quo} result is ready.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic        stall_div_o,
    output logic        ready_o,
    output logic [63:0] result_o
);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [64:0]          work_q, work_d;
    logic [31:0]          divisor_q, divisor_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [63:0]          result_q, result_d;
    logic                 ready_q, ready_d;
    logic [64:0]          step_work;

    div_unit_step u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (step_work)
    );

    // Stall drops in DONE so the pipeline advances, and immediately on a flush.
    assign stall_div_o = start_i & ~annul_i & (state_q != DIV_DONE);
    assign ready_o     = ready_q;
    assign result_o    = result_q;

    // Next-state, datapath latch and result fix-up.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = 1'b0;

        if (annul_i) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    cnt_d = '0;
                    if (start_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_d = DIV_ZERO;
                        end else begin
                            // Magnitudes as unsigned values, so |-2^31| = 0x8000_0000.
                            work_d    = {33'd0, neg_if(signed_i & opdata1_i[31], opdata1_i)};
                            divisor_d = neg_if(signed_i & opdata2_i[31], opdata2_i);
                            neg_quo_d = signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                            neg_rem_d = signed_i & opdata1_i[31];
                            state_d   = DIV_BUSY;
                        end
                    end
                end
                DIV_ZERO: begin
                    result_d = 64'h0;
                    ready_d  = 1'b1;
                    state_d  = DIV_DONE;
                end
                DIV_BUSY: begin
                    work_d = step_work;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == DIV_CNT_W'(DIV_ITER - 1)) begin
                        result_d[HI_MSB:HI_LSB] = neg_if(neg_rem_q, step_work[63:32]);
                        result_d[LO_MSB:LO_LSB] = neg_if(neg_quo_q, step_work[31:0]);
                        ready_d                 = 1'b1;
                        state_d                 = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    state_d = DIV_IDLE;
                end
                default: begin
                    state_d = DIV_IDLE;
                end
            endcase
        end
    end

    // State, counter, operands and registered outputs; all cleared on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results, monitor pops on ready_o.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic        stall_div_o;
    logic        ready_o;
    logic [63:0] result_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_hold = 64'h0;

    div_unit dut (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .annul_i     (annul_i),
        .stall_div_o (stall_div_o),
        .ready_o     (ready_o),
        .result_o    (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero; divisor 0 gives 0.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0]   sa, sb, sq, sr;
        logic        [63:0]   ua, ub, uq, ur;
        if (b == 32'd0) return 64'h0;
        if (s) begin
            sa = 64'($signed(a));
            sb = 64'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    // Issue one divide starting at a negedge; annul_at / rst_at < 0 disables those events.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int annul_at, input int rst_at);
        logic [63:0] exp;
        int          cyc;
        int          stall_cnt;
        int          exp_len;
        bit          done;
        bit          was_rst;
        exp       = model(s, a, b);
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        annul_i   = 1'b0;
        if (annul_at < 0 && rst_at < 0) sb_q.push_back(exp);
        exp_len   = (annul_at >= 0) ? annul_at : ((b == 32'd0) ? 2 : 33);
        cyc       = 0;
        stall_cnt = 0;
        done      = 1'b0;
        was_rst   = 1'b0;
        while (!done && cyc < 60) begin
            if (cyc == annul_at) annul_i = 1'b1;
            if (cyc == rst_at) begin
                resetn  = 1'b0;
                start_i = 1'b0;
                #1;
                chk("reset_mid_result", result_o, 64'h0);
                chk("reset_mid_ready", {63'd0, ready_o}, 64'd0);
                chk("reset_mid_state", {62'd0, dut.state_q}, {62'd0, DIV_IDLE});
                exp_hold = 64'h0;
                resetn   = 1'b1;
                #1;
                chk("reset_mid_stall", {63'd0, stall_div_o}, 64'd0);
                done    = 1'b1;
                was_rst = 1'b1;
            end else begin
                #1;
                if (stall_div_o) stall_cnt++;
                else done = 1'b1;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: stall still high after %0d cycles, required drop at %0d", cyc, exp_len);
        end else if (!was_rst) begin
            chk("stall_drop_cycle", 64'(cyc), 64'(exp_len));
            chk("stall_len", 64'(stall_cnt), 64'(exp_len));
            if (annul_at < 0) begin
                chk("ready_at_done", {63'd0, ready_o}, 64'd1);
                exp_hold = exp;
            end
        end
        @(negedge clk);
        if (annul_at >= 0) begin
            #1;
            chk("annul_state_idle", {62'd0, dut.state_q}, {62'd0, DIV_IDLE});
            chk("annul_ready_low", {63'd0, ready_o}, 64'd0);
            chk("annul_result_held", result_o, exp_hold);
        end
        start_i = 1'b0;
        annul_i = 1'b0;
    endtask

    // Monitor: every ready_o pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (ready_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: result %h with no divide outstanding", result_o);
                end else begin
                    chk("result", result_o, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic        s;
        logic [31:0] a, b;
        int          r;
        resetn    = 1'b0;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        #1;
        chk("reset_result", result_o, 64'h0);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_stall", {63'd0, stall_div_o}, 64'd0);
        chk("reset_count", {59'd0, dut.cnt_q}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_div(1'b0, 32'd7, 32'd2, -1, -1);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, -1, -1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, -1, -1);
        run_div(1'b1, 32'h8000_0000, 32'd1, -1, -1);
        run_div(1'b0, 32'd5, 32'd0, -1, -1);
        run_div(1'b1, 32'hFFFF_FFF0, 32'd0, -1, -1);
        run_div(1'b0, 32'd1234, 32'd5, 10, -1);
        run_div(1'b0, 32'd100, 32'd7, -1, -1);
        run_div(1'b0, 32'd9, 32'd3, -1, -1);
        run_div(1'b0, 32'd55, 32'd4, -1, 5);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            else if (r < 5) b = 32'($urandom_range(1, 20));
            else b = $urandom;
            if (r == 2 && s) b = ~b + 32'd1;
            if (r == 3) a = 32'($urandom_range(0, 50));
            run_div(s, a, b, -1, -1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
